// File: rtl/srlatch_driver.sv
// Timed en/s/r write sequencer for an external gated SR latch, one bit per handshake.
// Optional readback/retry path is compiled in with `define SRDRV_VERIFY_EN.
module srlatch_driver #(
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1,
  parameter int MAX_RETRY = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  input  logic req_data,
  output logic req_ready,
  output logic en,
  output logic s,
  output logic r,
  input  logic q_fb,
  output logic done,
  output logic err
);

  localparam int MAX_SP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_PH = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
  localparam int CW     = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;

  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    CHECK = 3'd4
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic          en_r, en_s;
  logic          set_r, set_s;
  logic          clr_r, clr_s;
  logic          ready_r, ready_s;
  logic          done_r, done_s;
  logic          err_r, err_s;

`ifdef SRDRV_VERIFY_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);
  localparam logic [RW-1:0] RETRY_ZERO = {RW{1'b0}};

  logic          sync1_r, sync2_r;
  logic          data_r, data_s;
  logic [RW-1:0] retry_r, retry_s;

  // q_fb is asynchronous to clk: two-flop synchronizer plus verify-path state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      data_r  <= 1'b0;
      retry_r <= RETRY_ZERO;
    end else begin
      sync1_r <= q_fb;
      sync2_r <= sync1_r;
      data_r  <= data_s;
      retry_r <= retry_s;
    end
  end
`else
  logic unused_q_fb_s;
  assign unused_q_fb_s = q_fb;
`endif

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      en_r    <= 1'b0;
      set_r   <= 1'b0;
      clr_r   <= 1'b0;
      ready_r <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      en_r    <= en_s;
      set_r   <= set_s;
      clr_r   <= clr_s;
      ready_r <= ready_s;
      done_r  <= done_s;
      err_r   <= err_s;
    end
  end

  // Next state and next registered-output values; s/r only move while en stays low
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    en_s    = 1'b0;
    set_s   = set_r;
    clr_s   = clr_r;
    ready_s = 1'b0;
    done_s  = 1'b0;
    err_s   = 1'b0;
`ifdef SRDRV_VERIFY_EN
    data_s  = data_r;
    retry_s = retry_r;
`endif
    case (state_r)
      IDLE: begin
        if (req_valid && ready_r) begin
          state_s = SETUP;
          cnt_s   = CNT_ZERO;
          set_s   = req_data;
          clr_s   = ~req_data;
`ifdef SRDRV_VERIFY_EN
          data_s  = req_data;
`endif
        end else begin
          ready_s = 1'b1;
          set_s   = 1'b0;
          clr_s   = 1'b0;
        end
      end
      SETUP: begin
        if (cnt_r == SETUP_LAST) begin
          state_s = PULSE;
          cnt_s   = CNT_ZERO;
          en_s    = 1'b1;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
      PULSE: begin
        if (cnt_r == PULSE_LAST) begin
          state_s = HOLD;
          cnt_s   = CNT_ZERO;
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
          en_s    = 1'b1;
        end
      end
      HOLD: begin
        if (cnt_r == HOLD_LAST) begin
          cnt_s   = CNT_ZERO;
          set_s   = 1'b0;
          clr_s   = 1'b0;
`ifdef SRDRV_VERIFY_EN
          state_s = CHECK;
`else
          state_s = IDLE;
          done_s  = 1'b1;
          ready_s = 1'b1;
`endif
        end else begin
          cnt_s   = cnt_r + CNT_ONE;
        end
      end
`ifdef SRDRV_VERIFY_EN
      CHECK: begin
        // Second cycle: sync2_r now holds q_fb as sampled at the end of HOLD
        if (cnt_r == CNT_ONE) begin
          cnt_s = CNT_ZERO;
          if (sync2_r == data_r) begin
            state_s = IDLE;
            done_s  = 1'b1;
            ready_s = 1'b1;
            retry_s = RETRY_ZERO;
          end else if (retry_r < RETRY_MAX) begin
            state_s = SETUP;
            retry_s = retry_r + RW'(1);
            set_s   = data_r;
            clr_s   = ~data_r;
          end else begin
            state_s = IDLE;
            err_s   = 1'b1;
            ready_s = 1'b1;
            retry_s = RETRY_ZERO;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
`endif
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
        set_s   = 1'b0;
        clr_s   = 1'b0;
      end
    endcase
  end

  assign req_ready = ready_r;
  assign en        = en_r;
  assign s         = set_r;
  assign r         = clr_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule

// File: tb/tb_srlatch_driver.sv
// Bench for srlatch_driver: timeline-based reference model with per-cycle compare,
// behavioural gated SR latch on q_fb, and directed write/retry/reset scenarios.
module tb_srlatch_driver;

  localparam int S  = 1;
  localparam int P  = 2;
  localparam int H  = 1;
  localparam int MR = 3;
  localparam int TH = S + P + H;
`ifdef SRDRV_VERIFY_EN
  localparam int LAT = TH + 2;
`else
  localparam int LAT = TH;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic req_data = 1'b0;
  logic req_ready, en, s, r, q_fb, done, err;

  int compared = 0;
  int mismatched = 0;

  // behavioural latch and readback forcing (0 follow, 1 stuck-0, 2 stuck-0 then follow)
  logic lq = 1'b0;
  int fb_mode = 0;

  srlatch_driver #(
    .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .en(en), .s(s), .r(r), .q_fb(q_fb),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(en or s or r) begin
    if (en && s) lq = 1'b1;
    else if (en && r) lq = 1'b0;
    else lq = lq;
  end

  assign q_fb = (fb_mode == 0) ? lq : 1'b0;

  task automatic check_bit(input string nm, input logic act, input logic req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %b required %b at %0t", nm, act, req, $time);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d required %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Reference model: outputs follow from cycles elapsed since the current T0
  logic exp_en = 1'b0, exp_s = 1'b0, exp_r = 1'b0;
  logic exp_ready = 1'b0, exp_done = 1'b0, exp_err = 1'b0;
  bit   busy = 1'b0;
  int   tt = 0;
  int   retries = 0;
  logic md = 1'b0;
`ifdef SRDRV_VERIFY_EN
  logic qcap = 1'b0;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy = 1'b0; tt = 0; retries = 0;
      exp_en = 1'b0; exp_s = 1'b0; exp_r = 1'b0;
      exp_ready = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
    end else begin
      exp_done = 1'b0;
      exp_err  = 1'b0;
      if (!busy) begin
        if (exp_ready && req_valid) begin
          busy = 1'b1; tt = 0; md = req_data; retries = 0;
        end
      end else begin
        tt = tt + 1;
      end
`ifdef SRDRV_VERIFY_EN
      if (busy && tt == TH) qcap = q_fb;
      if (busy && tt == LAT) begin
        if (qcap == md) begin
          exp_done = 1'b1; busy = 1'b0;
        end else if (retries < MR) begin
          retries = retries + 1; tt = 0;
        end else begin
          exp_err = 1'b1; busy = 1'b0;
        end
      end
`else
      if (busy && tt == LAT) begin
        exp_done = 1'b1; busy = 1'b0;
      end
`endif
      if (busy) begin
        exp_ready = 1'b0;
        exp_s  = (tt < TH) ? md : 1'b0;
        exp_r  = (tt < TH) ? ~md : 1'b0;
        exp_en = (tt >= S) && (tt < S + P);
      end else begin
        exp_ready = 1'b1; exp_s = 1'b0; exp_r = 1'b0; exp_en = 1'b0;
      end
    end
  end

  // Per-cycle compare against the model plus the latch-input invariants
  logic pv_s = 1'b0, pv_r = 1'b0, pv_en = 1'b0;
  bit   pv_ok = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      check_bit("en", en, exp_en);
      check_bit("s", s, exp_s);
      check_bit("r", r, exp_r);
      check_bit("req_ready", req_ready, exp_ready);
      check_bit("done", done, exp_done);
      check_bit("err", err, exp_err);
      check_bit("s_and_r", s & r, 1'b0);
      if (pv_ok)
        check_bit("sr_move_with_en", ((s !== pv_s) || (r !== pv_r)) && (en || pv_en), 1'b0);
      pv_s = s; pv_r = r; pv_en = en; pv_ok = 1'b1;
    end else begin
      pv_ok = 1'b0;
    end
  end

  // One request; returns at the negedge where done/err is seen (k = edges after accept)
  task automatic do_write(input logic d, output int lat, output int pulses, output int en_cyc,
                          output int n_done, output int n_err, output logic s0, output logic r0);
    int n;
    logic pen;
    req_valid = 1'b1;
    req_data  = d;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_bit("accept_in_time", (n < 50), 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    req_data  = ~d;
    s0 = s; r0 = r;
    lat = -1; pulses = 0; en_cyc = 0; n_done = 0; n_err = 0; pen = 1'b0;
    for (int k = 0; k < 80 && lat < 0; k++) begin
      if (en) en_cyc++;
      if (en && !pen) pulses++;
      pen = en;
      if (done) n_done++;
      if (err) n_err++;
      if (done || err) lat = k;
      if (k == 5 && fb_mode == 2) fb_mode = 0;
      if (lat < 0) @(negedge clk);
    end
    check_bit("finish_in_time", (lat >= 0), 1'b1);
  endtask

  initial begin
    int lat, pul, enc, nd, ne, ndone;
    logic s0, r0;

    // reset and release
    repeat (3) @(negedge clk);
    check_bit("rst_en", en, 1'b0);
    check_bit("rst_s", s, 1'b0);
    check_bit("rst_r", r, 1'b0);
    check_bit("rst_ready", req_ready, 1'b0);
    check_bit("rst_done", done, 1'b0);
    check_bit("rst_err", err, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_bit("ready_after_release", req_ready, 1'b1);
    check_bit("en_after_release", en, 1'b0);

    // write 1, then write 0
    do_write(1'b1, lat, pul, enc, nd, ne, s0, r0);
    check_int("w1_latency", lat, LAT);
    check_int("w1_pulses", pul, 1);
    check_int("w1_en_cycles", enc, 2);
    check_int("w1_done", nd, 1);
    check_int("w1_err", ne, 0);
    check_bit("w1_s", s0, 1'b1);
    check_bit("w1_r", r0, 1'b0);
    check_bit("w1_q", lq, 1'b1);

    do_write(1'b0, lat, pul, enc, nd, ne, s0, r0);
    check_int("w0_latency", lat, LAT);
    check_int("w0_en_cycles", enc, 2);
    check_int("w0_done", nd, 1);
    check_bit("w0_s", s0, 1'b0);
    check_bit("w0_r", r0, 1'b1);
    check_bit("w0_q", lq, 1'b0);

    // back-to-back with req_valid held: spacing LAT+1
    req_valid = 1'b1;
    ndone = 0;
    for (int k = 0; k < 3 * (LAT + 1); k++) begin
      @(negedge clk);
      req_data = k[0];
      if (done) ndone++;
    end
    req_valid = 1'b0;
    check_int("b2b_done_count", ndone, 3);
    repeat (2) @(negedge clk);

    // reset during PULSE
    req_valid = 1'b1;
    req_data  = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check_bit("pulse_before_reset", en, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_bit("mid_rst_en", en, 1'b0);
    check_bit("mid_rst_s", s, 1'b0);
    check_bit("mid_rst_r", r, 1'b0);
    check_bit("mid_rst_done", done, 1'b0);
    check_bit("mid_rst_err", err, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_bit("ready_after_mid_rst", req_ready, 1'b1);
    do_write(1'b0, lat, pul, enc, nd, ne, s0, r0);
    check_int("post_rst_latency", lat, LAT);
    check_int("post_rst_done", nd, 1);
    check_bit("post_rst_q", lq, 1'b0);

`ifdef SRDRV_VERIFY_EN
    // readback stuck at 0: 1 + MR attempts, then err
    fb_mode = 1;
    do_write(1'b1, lat, pul, enc, nd, ne, s0, r0);
    check_int("stuck_latency", lat, 24);
    check_int("stuck_pulses", pul, 4);
    check_int("stuck_done", nd, 0);
    check_int("stuck_err", ne, 1);
    check_bit("stuck_ready", req_ready, 1'b1);
    fb_mode = 0;
    @(negedge clk);

    // one mismatch, then readback follows the latch
    fb_mode = 2;
    do_write(1'b1, lat, pul, enc, nd, ne, s0, r0);
    check_int("once_latency", lat, 12);
    check_int("once_pulses", pul, 2);
    check_int("once_done", nd, 1);
    check_int("once_err", ne, 0);
    fb_mode = 0;
`endif

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
